// File: rtl/sample_storage.sv
// Audio delay line. Each accepted sample goes into a per-channel ring buffer in
// SDRAM, and the sample written DELAY samples earlier on that channel is read back
// and presented on a valid/ready output.
// Ports:
//   clk50/rst             : clock and async active-low reset
//   idata/ivalid/iready   : sample input; iready is a one-cycle accept pulse
//   odata/ovalid/oready   : delayed sample output, held until oready
//   write/waddr/wdata     : SDRAM write request
//   read/raddr            : SDRAM read request
//   rdata/read_ready/busy : SDRAM responses
//   channel               : 0 = left, 1 = right; sampled on accept
//   lrclk                 : asynchronous codec LR clock; each edge re-arms capture
//   state                 : current FSM state code, for debug
module sample_storage #(
  parameter int BUF_DEPTH = 48000,
  parameter int DELAY     = 24000
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic [15:0] idata,
  input  logic        ivalid,
  output logic        iready,
  output logic [15:0] odata,
  output logic        ovalid,
  input  logic        oready,
  output logic        write,
  output logic [24:0] waddr,
  output logic [15:0] wdata,
  output logic        read,
  output logic [24:0] raddr,
  input  logic [15:0] rdata,
  input  logic        read_ready,
  input  logic        busy,
  input  logic        channel,
  input  logic        lrclk,
  output logic [4:0]  state
);

  localparam logic [23:0] DEPTH_W  = 24'(BUF_DEPTH);
  localparam logic [23:0] DELAY_W  = 24'(DELAY);
  localparam logic [23:0] LAST_IDX = 24'(BUF_DEPTH - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'd0,
    CAPTURE = 5'd1,
    WR_REQ  = 5'd2,
    WR_WAIT = 5'd3,
    RD_REQ  = 5'd4,
    RD_WAIT = 5'd5,
    OUT     = 5'd6
  } state_t;

  state_t      cur_state;
  state_t      nxt_state;
  logic [2:0]  lr_sync;
  logic        lr_edge;
  logic        armed;
  logic        accept;
  logic        ch_q;
  logic [23:0] wptr [2];
  logic [23:0] cur_ptr;
  logic [23:0] rd_idx;

  assign state  = cur_state;
  assign write  = (cur_state == WR_REQ);
  assign ovalid = (cur_state == OUT);

  // Two flops synchronize lrclk; the third holds the previous value for edge detection.
  assign lr_edge = lr_sync[2] ^ lr_sync[1];
  assign accept  = (cur_state == IDLE) && ivalid && armed;

  // Read index trails the write index by DELAY, modulo the ring depth.
  always_comb begin
    cur_ptr = wptr[channel];
    rd_idx  = (cur_ptr >= DELAY_W) ? (cur_ptr - DELAY_W) : (cur_ptr + DEPTH_W - DELAY_W);
  end

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (accept) nxt_state = CAPTURE;
      CAPTURE: nxt_state = WR_REQ;
      WR_REQ:  if (busy) nxt_state = WR_WAIT;
      WR_WAIT: if (!busy) nxt_state = RD_REQ;
      RD_REQ:  if (busy) nxt_state = RD_WAIT;
      // read drops once data is captured; leave only when the controller is idle too.
      RD_WAIT: if (!read && !busy) nxt_state = OUT;
      OUT:     if (oready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      lr_sync <= 3'b000;
      armed   <= 1'b1;
    end else begin
      lr_sync <= {lr_sync[1:0], lrclk};
      // A new half-period wins over a same-cycle capture so it is not lost.
      if (lr_edge) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      iready  <= 1'b0;
      wdata   <= 16'd0;
      waddr   <= 25'd0;
      raddr   <= 25'd0;
      odata   <= 16'd0;
      read    <= 1'b0;
      ch_q    <= 1'b0;
      wptr[0] <= 24'd0;
      wptr[1] <= 24'd0;
    end else begin
      iready <= accept;
      if (accept) begin
        wdata <= idata;
        ch_q  <= channel;
        waddr <= {channel, cur_ptr};
        raddr <= {channel, rd_idx};
      end
      if ((cur_state == WR_WAIT) && !busy) begin
        wptr[ch_q] <= (wptr[ch_q] == LAST_IDX) ? 24'd0 : (wptr[ch_q] + 24'd1);
        read       <= 1'b1;
      end
      // Only the first read_ready of a transaction is taken.
      if ((cur_state == RD_WAIT) && read && read_ready) begin
        odata <= rdata;
        read  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_storage.sv
// Bench for sample_storage: reset, table-driven single transactions, arming,
// mid-operation reset and a randomized stream against a ring-buffer model.
module tb_sample_storage;

  localparam int BD = 40;
  localparam int DL = 15;

  logic        clk50 = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] idata = 16'd0;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [15:0] odata;
  logic        ovalid;
  logic        oready = 1'b0;
  logic        write;
  logic [24:0] waddr;
  logic [15:0] wdata;
  logic        read;
  logic [24:0] raddr;
  logic [15:0] rdata = 16'd0;
  logic        read_ready = 1'b0;
  logic        busy = 1'b0;
  logic        channel = 1'b0;
  logic        lrclk = 1'b0;
  logic [4:0]  state;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [2][BD];
  logic [15:0] hist [2][$];

  typedef struct {
    logic        ch;
    logic [15:0] d;
    int          blat;
    int          olat;
    logic [24:0] ew;
    logic [24:0] er;
    logic [15:0] eo;
  } vec_t;

  vec_t vecs [5];

  sample_storage #(.BUF_DEPTH(BD), .DELAY(DL)) dut (
    .clk50(clk50), .rst(rst), .idata(idata), .ivalid(ivalid), .iready(iready),
    .odata(odata), .ovalid(ovalid), .oready(oready), .write(write), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rdata(rdata), .read_ready(read_ready),
    .busy(busy), .channel(channel), .lrclk(lrclk), .state(state)
  );

  always #10 clk50 = ~clk50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int c, input int idx);
    return 16'(16'hC000 + c * 256 + idx);
  endfunction

  task automatic init_mem();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < BD; i++)
        mem[c][i] = init_val(c, i);
  endtask

  // Acts as producer, SDRAM controller and consumer for one sample.
  task automatic do_sample(input logic c, input logic [15:0] d, input int blat, input int olat,
                           input logic [24:0] ew, input logic [24:0] er, input logic [15:0] eo);
    int n;
    lrclk = ~lrclk;
    repeat (4) @(negedge clk50);
    idata = d; channel = c; ivalid = 1'b1;
    n = 0;
    while (!iready && n < 20) begin @(negedge clk50); n++; end
    chk("iready_seen", iready, 1);
    ivalid = 1'b0; idata = 16'hDEAD; channel = ~c;
    @(negedge clk50);
    chk("iready_width", iready, 0);
    n = 0;
    while (!write && n < 20) begin @(negedge clk50); n++; end
    chk("write_req", write, 1);
    chk("waddr", waddr, ew);
    chk("wdata", wdata, d);
    chk("read_during_write", read, 0);
    repeat (blat) @(negedge clk50);
    chk("write_hold", write, 1);
    busy = 1'b1;
    @(negedge clk50);
    chk("write_drop", write, 0);
    if (waddr[23:0] < BD) mem[waddr[24]][waddr[23:0]] = wdata;
    @(negedge clk50);
    busy = 1'b0;
    n = 0;
    while (!read && n < 20) begin @(negedge clk50); n++; end
    chk("read_req", read, 1);
    chk("raddr", raddr, er);
    chk("write_during_read", write, 0);
    repeat (blat) @(negedge clk50);
    chk("read_hold", read, 1);
    busy = 1'b1;
    @(negedge clk50);
    chk("read_hold_busy", read, 1);
    rdata = (raddr[23:0] < BD) ? mem[raddr[24]][raddr[23:0]] : 16'h0BAD;
    read_ready = 1'b1;
    @(negedge clk50);
    read_ready = 1'b0; rdata = 16'hBAD0;
    chk("read_drop", read, 0);
    @(negedge clk50);
    busy = 1'b0;
    n = 0;
    while (!ovalid && n < 20) begin @(negedge clk50); n++; end
    chk("ovalid", ovalid, 1);
    chk("odata", odata, eo);
    ivalid = (olat > 0);
    idata = 16'(16'h5A00 + olat);
    for (int i = 0; i < olat; i++) begin
      @(negedge clk50);
      chk("ovalid_hold", ovalid, 1);
      chk("odata_stable", odata, eo);
      chk("no_iready_in_out", iready, 0);
    end
    ivalid = 1'b0; oready = 1'b1;
    @(negedge clk50);
    oready = 1'b0;
    chk("ovalid_drop", ovalid, 0);
    chk("back_to_idle", state, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int k;
    logic        c;
    logic [15:0] d;
    logic [15:0] eo;

    vecs[0] = '{1'b0, 16'd5,  0, 0, 25'd0,                        25'd25,                        16'hC019};
    vecs[1] = '{1'b1, 16'd7,  1, 2, {1'b1, 24'd0},                {1'b1, 24'd25},                16'hC119};
    vecs[2] = '{1'b0, 16'd9,  2, 10, 25'd1,                       25'd26,                        16'hC01A};
    vecs[3] = '{1'b0, 16'd11, 3, 1, 25'd2,                        25'd27,                        16'hC01B};
    vecs[4] = '{1'b1, 16'd13, 0, 3, {1'b1, 24'd1},                {1'b1, 24'd26},                16'hC11A};
    init_mem();

    // Reset state
    #40;
    chk("rst_iready", iready, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_odata", odata, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_state", state, 0);
    @(negedge clk50);
    rst = 1'b1;
    @(negedge clk50);

    foreach (vecs[i])
      do_sample(vecs[i].ch, vecs[i].d, vecs[i].blat, vecs[i].olat, vecs[i].ew, vecs[i].er, vecs[i].eo);

    // Without a new lrclk edge, a held ivalid must not be captured again.
    ivalid = 1'b1; idata = 16'h7777;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50);
      if (iready) cnt++;
    end
    ivalid = 1'b0;
    chk("no_capture_same_half", cnt, 0);
    chk("idle_when_unarmed", state, 0);

    // Mid-operation reset aborts and restarts both pointers.
    lrclk = ~lrclk;
    repeat (4) @(negedge clk50);
    ivalid = 1'b1; channel = 1'b1; idata = 16'h4444;
    n = 0;
    while (!iready && n < 20) begin @(negedge clk50); n++; end
    chk("abort_iready", iready, 1);
    ivalid = 1'b0;
    n = 0;
    while (!write && n < 20) begin @(negedge clk50); n++; end
    chk("abort_write", write, 1);
    busy = 1'b1;
    @(negedge clk50);
    rst = 1'b0;
    #1;
    chk("abort_state", state, 0);
    chk("abort_write_low", write, 0);
    chk("abort_read_low", read, 0);
    chk("abort_waddr", waddr, 0);
    @(negedge clk50);
    busy = 1'b0; rst = 1'b1;
    @(negedge clk50);
    do_sample(1'b0, 16'h1234, 1, 2, 25'd0, 25'd25, 16'hC019);
    do_sample(1'b1, 16'h2345, 0, 0, {1'b1, 24'd0}, {1'b1, 24'd25}, 16'hC119);

    // Randomized stream against a ring-buffer model from a clean start.
    init_mem();
    @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);
    rst = 1'b1;
    @(negedge clk50);
    hist[0].delete();
    hist[1].delete();
    for (int s = 0; s < 150; s++) begin
      c = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      k = hist[c].size();
      eo = (k >= DL) ? hist[c][k - DL] : init_val(int'(c), (k + BD - DL) % BD);
      do_sample(c, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {c, 24'(k % BD)}, {c, 24'((k + BD - DL) % BD)}, eo);
      hist[c].push_back(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_storage.md
Name: sample_storage

Overview:
- Audio delay line backed by external SDRAM, on the 50 MHz system clock between the audio codec sample stream and downstream effects.
- Each accepted 16-bit sample is written to a per-channel circular buffer. The sample written DELAY samples earlier on the same channel is read back and presented on a valid/ready output.
- Drives a simple request/busy SDRAM controller interface.

Parameters:
- BUF_DEPTH, 48000, samples per channel ring buffer; must be ≤ 2^24.
- DELAY, 24000, delay in samples per channel; 1 ≤ DELAY < BUF_DEPTH.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- idata  in  16  input audio sample.
- ivalid  in  1  idata valid.
- iready  out  1  one-cycle accept pulse.
- odata  out  16  delayed sample.
- ovalid  out  1  odata valid.
- oready  in  1  consumer accepts odata.
- write  out  1  SDRAM write request.
- waddr  out  25  SDRAM write address.
- wdata  out  16  SDRAM write data.
- read  out  1  SDRAM read request.
- raddr  out  25  SDRAM read address.
- rdata  in  16  SDRAM read data.
- read_ready  in  1  rdata valid.
- busy  in  1  SDRAM controller busy.
- channel  in  1  0 = left, 1 = right; sampled at capture.
- lrclk  in  1  codec LR clock, asynchronous; 2-flop synchronized internally.
- state  out  5  current FSM state code, for debug.

Behaviour:
- Reset (rst low, async): FSM → IDLE. Outputs iready, ovalid, read, write, odata, waddr, raddr, wdata all 0. Both channel write pointers 0. Arm flag set.
- Arm flag: set on every edge (either direction) of synchronized lrclk; cleared on capture. Guarantees at most one capture per lrclk half-period.
- Addressing: bit 24 = channel. Bits 23:0 = ring index.
  - waddr index = wptr[ch].
  - raddr index = wptr[ch] − DELAY if wptr[ch] ≥ DELAY, else wptr[ch] + BUF_DEPTH − DELAY.
- FSM (state codes in brackets):
  - IDLE(0): if ivalid and armed → CAPTURE. Latch idata into wdata. Latch channel. Compute waddr/raddr. Pulse iready for exactly one cycle. Clear arm.
  - CAPTURE(1): → WR_REQ.
  - WR_REQ(2): write=1; waddr/wdata held. When busy=1: write=0 → WR_WAIT.
  - WR_WAIT(3): when busy=0, increment wptr[ch] (BUF_DEPTH−1 wraps to 0) → RD_REQ.
  - RD_REQ(4): read=1; raddr held. When busy=1 → RD_WAIT. Keep read=1.
  - RD_WAIT(5): on first cycle with read_ready=1: odata ← rdata; read=0. Then wait for busy=0 → OUT.
  - OUT(6): ovalid=1, odata held. When oready=1: ovalid=0 → IDLE.
- Request outputs stay asserted until busy seen high, tolerating ≥2-cycle controller latency. No timeout.
- Per sample: one write then one read, never simultaneous.
- ivalid while not in IDLE is ignored; no iready is issued.
- Before the buffer fills, read data is whatever the SDRAM holds and is passed through unmodified.
- Left and right pointers advance independently. Wrap-around on raddr and waddr is seamless.
- Unused state codes (7–31) → IDLE.
- Mid-operation reset aborts the transaction immediately; the pointers restart at 0.

Test Plan:
- Reset: hold rst low 40 ns → all outputs 0, state=0. Release → ivalid with lrclk toggling yields iready pulse width exactly 20 ns.
- Single sample, ch=0, idata=5, pointers at 0: waddr=0, wdata=5, write held until busy. Then raddr=24000 and read. read_ready with rdata=8 → odata=8, ovalid until oready pulse.
- Channel select: ch=1 → waddr bit24=1, index = right pointer (left pointer unchanged).
- Delay check: stream idata 1..48000 into ch=0 with a memory model → sample n ≥ 24001 outputs odata = n−24000.
- Wrap: after 48000 writes on ch=0, wptr=0, next waddr=0, raddr=24000. Write at wptr=47999 gives raddr=23999.
- Protocol: ivalid held high across one lrclk half-period → exactly one capture. Busy latency of 2 cycles with read_ready 1 cycle after busy → correct single capture of rdata. oready delayed 10 cycles → odata stable, no new iready until OUT exits.
